// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer that owns the PC and IR and steers a 16-register ALU datapath.
// Each instruction takes 3 cycles at zero wait. FETCH and MEM hold the request until mem_ack; HALT is left only by reset.
module instr_sequencer #(
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ack,
    input  logic [15:0]       rs1_data,
    input  logic [15:0]       rs2_data,
    input  logic              flag_z,
    output logic              sel_imm,
    output logic [15:0]       imm,
    output logic [3:0]        alu_op,
    output logic [3:0]        sel1,
    output logic [3:0]        sel2,
    output logic [4:0]        reg_en,
    output logic              wb_sel,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       ir,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_START,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_RTYPE  = 4'h0;
    localparam logic [3:0] OP_ADDI   = 4'h1;
    localparam logic [3:0] OP_MOVI   = 4'h2;
    localparam logic [3:0] OP_CMPI   = 4'h3;
    localparam logic [3:0] OP_MEM    = 4'h4;
    localparam logic [3:0] OP_BCC    = 4'hC;
    localparam logic [3:0] OP_HALT   = 4'hF;

    localparam logic [3:0] ALU_ADD   = 4'h5;
    localparam logic [3:0] ALU_CMP   = 4'hB;
    localparam logic [3:0] ALU_MOV   = 4'hD;

    localparam logic [3:0] MEM_LOAD  = 4'h0;
    localparam logic [3:0] MEM_STOR  = 4'h4;

    localparam logic [3:0] COND_Z    = 4'h0;
    localparam logic [3:0] COND_NZ   = 4'h1;
    localparam logic [3:0] COND_AL   = 4'hE;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;

    logic [3:0]        opcode;
    logic [3:0]        rd_f;
    logic [3:0]        fn_f;
    logic [3:0]        rs_f;
    logic [ADDR_W-1:0] imm_ext;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] rs2_addr;
    logic              br_taken;
    logic              mem_op_ok;

    assign opcode   = ir_q[15:12];
    assign rd_f     = ir_q[11:8];
    assign fn_f     = ir_q[7:4];
    assign rs_f     = ir_q[3:0];
    assign imm_ext  = {{(ADDR_W-8){ir_q[7]}}, ir_q[7:0]};
    assign pc_inc   = pc_q + ADDR_W'(1);
    assign rs2_addr = ADDR_W'(rs2_data);
    assign mem_op_ok = (fn_f == MEM_LOAD) || (fn_f == MEM_STOR);

    assign imm       = {{8{ir_q[7]}}, ir_q[7:0]};
    assign mem_wdata = rs1_data;
    assign pc        = pc_q;
    assign ir        = ir_q;

    // flag_z is already registered in the datapath, so it reflects the last ALU op.
    always_comb begin
        br_taken = 1'b0;
        case (rd_f)
            COND_Z:  br_taken = flag_z;
            COND_NZ: br_taken = ~flag_z;
            COND_AL: br_taken = 1'b1;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = pc_q;
        sel_imm  = 1'b0;
        alu_op   = 4'h0;
        sel1     = 4'h0;
        sel2     = 4'h0;
        reg_en   = 5'b0;
        wb_sel   = 1'b0;
        halted   = 1'b0;

        case (state_q)
            S_START: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                case (opcode)
                    OP_MEM:  state_d = S_MEM;
                    OP_HALT: state_d = S_HALT;
                    default: state_d = S_EXEC;
                endcase
            end

            S_EXEC: begin
                pc_d    = pc_inc;
                state_d = S_FETCH;
                case (opcode)
                    OP_RTYPE: begin
                        alu_op = fn_f;
                        sel1   = rd_f;
                        sel2   = rs_f;
                        reg_en = {fn_f != ALU_CMP, rd_f};
                    end
                    OP_ADDI: begin
                        alu_op  = ALU_ADD;
                        sel1    = rd_f;
                        sel_imm = 1'b1;
                        reg_en  = {1'b1, rd_f};
                    end
                    OP_MOVI: begin
                        alu_op  = ALU_MOV;
                        sel_imm = 1'b1;
                        reg_en  = {1'b1, rd_f};
                    end
                    OP_CMPI: begin
                        alu_op  = ALU_CMP;
                        sel1    = rd_f;
                        sel_imm = 1'b1;
                    end
                    OP_BCC: begin
                        if (br_taken) begin
                            pc_d = pc_q + imm_ext;
                        end
                    end
                    default: ;
                endcase
            end

            S_MEM: begin
                sel1     = rd_f;
                sel2     = rs_f;
                mem_addr = rs2_addr;
                case (fn_f)
                    MEM_LOAD: begin
                        mem_req = 1'b1;
                        wb_sel  = 1'b1;
                        // Write strobe only in the ack cycle so mem_rdata is valid at the regfile.
                        if (mem_ack) begin
                            reg_en = {1'b1, rd_f};
                        end
                    end
                    MEM_STOR: begin
                        mem_req = 1'b1;
                        mem_we  = 1'b1;
                    end
                    default: ;
                endcase
                if (!mem_op_ok || mem_ack) begin
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end

            S_HALT: begin
                halted = 1'b1;
            end

            default: begin
                state_d = S_START;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_START;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

endmodule
